// File: rtl/core_run_ctrl_pkg.sv
// Shared types and widths for the core run-control sequencer.
// Optional feature macro: CORE_RUN_CTRL_WDOG_EN (adds the FAULT state).
package core_run_ctrl_pkg;

  localparam int RETIRED_W = 32;
  localparam int STATE_W   = 3;

  // Encodings are visible on o_state, so they are fixed explicitly.
  typedef enum logic [STATE_W-1:0] {
    ST_RST_HOLD = 3'd0,
    ST_RUN      = 3'd1,
    ST_PAUSE    = 3'd2,
    ST_STEP     = 3'd3,
    ST_HALTED   = 3'd4
`ifdef CORE_RUN_CTRL_WDOG_EN
    ,ST_FAULT   = 3'd5
`endif
  } run_state_t;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Bundle of board/core-side signals of the run-control sequencer.
// master = board/core side driving inputs, slave = the sequencer.
interface core_run_ctrl_if;

  logic                                  i_run_sw;
  logic                                  i_step_key;
  logic                                  i_insn_vld;
  logic                                  i_halt;
  logic                                  o_core_reset;
  logic                                  o_core_en;
  logic [core_run_ctrl_pkg::STATE_W-1:0] o_state;
  logic [core_run_ctrl_pkg::RETIRED_W-1:0] o_retired;
  logic                                  o_step_done;

  modport master (
    output i_run_sw, i_step_key, i_insn_vld, i_halt,
    input  o_core_reset, o_core_en, o_state, o_retired, o_step_done
  );

  modport slave (
    input  i_run_sw, i_step_key, i_insn_vld, i_halt,
    output o_core_reset, o_core_en, o_state, o_retired, o_step_done
  );

endinterface

// File: rtl/core_run_ctrl_debounce.sv
// Two-flop synchroniser, stability counter and falling-edge pulse for a
// raw push-button. The accepted level only moves after DEBOUNCE_CYCLES
// consecutive synced samples that disagree with it.
module core_run_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state: shift the synchroniser, count disagreeing samples, flip level.
  always_comb begin
    sync1_d = i_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Register all debounce state; everything clears on reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run-control sequencer: power-on reset hold, run/pause/single-step/halt
// clock-enable generation and retired-instruction counting for the core.
// Optional feature macro: CORE_RUN_CTRL_WDOG_EN (watchdog -> FAULT state).
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_TIMEOUT    = 64
`ifdef CORE_RUN_CTRL_WDOG_EN
  ,parameter int WDOG_CYCLES    = 1000000
`endif
) (
  input  logic            i_clk,
  input  logic            i_reset,
  core_run_ctrl_if.slave  bus
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int STEP_W = $clog2(STEP_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TIMEOUT - 1);
  localparam logic [RETIRED_W-1:0] RETIRED_MAX = {RETIRED_W{1'b1}};
`ifdef CORE_RUN_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

  run_state_t           state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic [RETIRED_W-1:0] retired_q, retired_d;
  logic                 core_reset_q, core_reset_d;
  logic                 core_en_q, core_en_d;
  logic                 step_done_q, step_done_d;
  logic                 run_meta_q, run_sync_q;
  logic                 key_level_s, key_fall_s, step_press_s;

  core_run_ctrl_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_key (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_raw   (bus.i_step_key),
    .o_level (key_level_s),
    .o_fall  (key_fall_s)
  );

  // The accepted level is already low whenever the fall pulse is up.
  assign step_press_s = key_fall_s & ~key_level_s;

  // Run switch is synchronised only; a switch does not bounce back into run.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
    end else begin
      run_meta_q <= bus.i_run_sw;
      run_sync_q <= run_meta_q;
    end
  end

  // Next-state, counters and output decode; halt > run_sw > step end > press.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    step_cnt_d  = step_cnt_q;
    step_done_d = 1'b0;
`ifdef CORE_RUN_CTRL_WDOG_EN
    wdog_cnt_d  = '0;
`endif
    if (core_en_q && bus.i_insn_vld && (retired_q != RETIRED_MAX)) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end

    case (state_q)
      ST_RST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = run_sync_q ? ST_RUN : ST_PAUSE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
`ifdef CORE_RUN_CTRL_WDOG_EN
        wdog_cnt_d = bus.i_insn_vld ? '0 : (wdog_cnt_q + WDOG_W'(1));
`endif
        if (bus.i_halt) begin
          state_d = ST_HALTED;
        end else if (!run_sync_q) begin
          state_d = ST_PAUSE;
`ifdef CORE_RUN_CTRL_WDOG_EN
        end else if (!bus.i_insn_vld && (wdog_cnt_q == WDOG_LAST)) begin
          state_d = ST_FAULT;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (bus.i_halt) begin
          state_d = ST_HALTED;
        end else if (run_sync_q) begin
          state_d = ST_RUN;
        end else if (step_press_s) begin
          state_d    = ST_STEP;
          step_cnt_d = '0;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_STEP: begin
        if (bus.i_halt) begin
          state_d = ST_HALTED;
        end else if (run_sync_q) begin
          state_d = ST_RUN;
        end else if (bus.i_insn_vld || (step_cnt_q == STEP_LAST)) begin
          state_d     = ST_PAUSE;
          step_done_d = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
`ifdef CORE_RUN_CTRL_WDOG_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif
      default: begin
        // Unreachable encodings park the core safely stopped.
        state_d = ST_HALTED;
      end
    endcase

    core_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    core_reset_d = (state_d != ST_RST_HOLD);
  end

  // State, counter and registered-output flops.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_RST_HOLD;
      hold_cnt_q   <= '0;
      step_cnt_q   <= '0;
      retired_q    <= '0;
      core_reset_q <= 1'b0;
      core_en_q    <= 1'b0;
      step_done_q  <= 1'b0;
`ifdef CORE_RUN_CTRL_WDOG_EN
      wdog_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      step_cnt_q   <= step_cnt_d;
      retired_q    <= retired_d;
      core_reset_q <= core_reset_d;
      core_en_q    <= core_en_d;
      step_done_q  <= step_done_d;
`ifdef CORE_RUN_CTRL_WDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
`endif
    end
  end

  assign bus.o_state      = state_q;
  assign bus.o_core_reset = core_reset_q;
  assign bus.o_core_en    = core_en_q;
  assign bus.o_retired    = retired_q;
  assign bus.o_step_done  = step_done_q;

endmodule
